uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter. Generalises the fixed 415-cycle baud ticker into a full framed serial TX.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_frame_if.sv | 19 +
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_frame.sv | 144 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: TX state encoding, idle line level, frame-length arithmetic.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // CLKIN cycles from the first start-bit cycle to the end of the last stop bit
    function automatic int unsigned frame_cycles(input int unsigned div,
                                                 input int unsigned bits,
                                                 input int unsigned par,
                                                 input int unsigned stop);
        return (32'd1 + bits + par + stop) * div;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-to-transmitter word handshake (data/valid/ready).
// parity_odd is present only when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_tx_frame_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
`ifdef UART_TX_PARITY_EN
    logic                 parity_odd;

    modport master (output data, output valid, output parity_odd, input ready);
    modport slave  (input data, input valid, input parity_odd, output ready);
`else
    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
`endif
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running divide-by-CLK_DIV bit timer; restart realigns it to the start of a bit.
`timescale 1ns/1ps
module uart_baud_gen #(
    parameter int unsigned CLK_DIV = 415
) (
    input  logic CLKIN,
    input  logic RESET,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // counter wraps on the last count so it never leaves 0..CLK_DIV-1
    always_ff @(posedge CLKIN) begin
        if (RESET || restart) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Framed UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit and the parity_odd handshake field.
`timescale 1ns/1ps
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 415,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              CLKIN,
    input  logic              RESET,
    uart_tx_frame_if.slave    tx_bus,
    output logic              busy,
    output logic              out
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    tx_state_t            state_q, state_nxt;
    logic [DATA_BITS-1:0] shreg_q, shreg_nxt;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic                 out_q, out_nxt;
    logic                 ready_q, ready_nxt;
    logic                 busy_q;
    logic                 accept_c;
    logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_nxt;
`endif

    assign accept_c     = tx_bus.valid && ready_q;
    assign tx_bus.ready = ready_q;
    assign busy         = busy_q;
    assign out          = out_q;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .CLKIN    (CLKIN),
        .RESET    (RESET),
        .restart  (accept_c),
        .bit_tick (bit_tick)
    );

    // state and registered line outputs
    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            out_q   <= UART_IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            shreg_q <= shreg_nxt;
            idx_q   <= idx_nxt;
            out_q   <= out_nxt;
            ready_q <= ready_nxt;
            busy_q  <= !ready_nxt;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_nxt;
`endif
        end
    end

    // next-state: bit sequencing driven by the baud tick
    always_comb begin
        state_nxt = state_q;
        shreg_nxt = shreg_q;
        idx_nxt   = idx_q;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = START;
                    shreg_nxt = tx_bus.data;
                    idx_nxt   = '0;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = (^tx_bus.data) ^ tx_bus.parity_odd;
`endif
                end
            end
            START: begin
                if (bit_tick) state_nxt = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_nxt = shreg_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_nxt = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    if (idx_q == STOP_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // output decode from the upcoming state so the pin is registered without extra latency
    always_comb begin
        out_nxt   = UART_IDLE_LEVEL;
        ready_nxt = (state_nxt == IDLE);
        case (state_nxt)
            START:   out_nxt = 1'b0;
            DATA:    out_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  out_nxt = par_nxt;
`endif
            default: out_nxt = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame against a bit-list frame model; honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int unsigned NB   = 8;
    localparam int unsigned DIV  = 4;
    localparam int unsigned DIV2 = 415;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned F  = (1 + NB + PB + 1) * DIV;
    localparam int unsigned F2 = (1 + NB + PB + 2) * DIV2;

    logic CLKIN = 1'b0;
    logic RESET;
    logic busy1, out1, busy2, out2;
    logic odd1, odd2;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLKIN = ~CLKIN;

    uart_tx_frame_if #(.DATA_BITS(NB)) bus1 ();
    uart_tx_frame_if #(.DATA_BITS(NB)) bus2 ();
`ifdef UART_TX_PARITY_EN
    assign bus1.parity_odd = odd1;
    assign bus2.parity_odd = odd2;
`endif

    uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(NB), .STOP_BITS(1)) dut (
        .CLKIN(CLKIN), .RESET(RESET), .tx_bus(bus1), .busy(busy1), .out(out1));

    uart_tx_frame #(.CLK_DIV(DIV2), .DATA_BITS(NB), .STOP_BITS(2)) dut2 (
        .CLKIN(CLKIN), .RESET(RESET), .tx_bus(bus2), .busy(busy2), .out(out2));

    // expected line level at cycle cyc of a frame: bit list start, data LSB first, parity, stops
    function automatic logic exp_level(input logic [7:0] w, input logic odd,
                                       input int unsigned cyc, input int unsigned div);
        int unsigned b;
        b = cyc / div;
        if (b == 0) return 1'b0;
        if (b <= NB) return w[b-1];
        if (PB == 1 && b == NB + 1) return (^w) ^ odd;
        return 1'b1;
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        bus1.valid = 1'b0; bus1.data = '0; odd1 = 1'b0;
        bus2.valid = 1'b0; bus2.data = '0; odd2 = 1'b0;
        repeat (3) @(posedge CLKIN);
        @(negedge CLKIN);
        RESET = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLKIN);
            checks++;
            if ({out1, bus1.ready, busy1} !== 3'b110) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d out/ready/busy=%b required=110", c, {out1, bus1.ready, busy1});
            end
            checks++;
            if ({out2, bus2.ready, busy2} !== 3'b110) begin
                failures++;
                $display("FAIL reset_idle2 cycle=%0d out/ready/busy=%b required=110", c, {out2, bus2.ready, busy2});
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] w, input logic odd);
        int low;
        low = 0;
        @(negedge CLKIN);
        checks++;
        if (bus1.ready !== 1'b1) begin
            failures++;
            $display("FAIL frame_ready_before word=%h ready=%b required=1", w, bus1.ready);
        end
        bus1.data = w; bus1.valid = 1'b1; odd1 = odd;
        @(posedge CLKIN);
        #1;
        bus1.valid = 1'b0;
        bus1.data  = 8'($urandom);
        odd1       = 1'($urandom);
        for (int c = 0; c < int'(F); c++) begin
            @(negedge CLKIN);
            checks++;
            if ({out1, bus1.ready, busy1} !== {exp_level(w, odd, c, DIV), 2'b01}) begin
                failures++;
                $display("FAIL frame word=%h cycle=%0d out/ready/busy=%b required=%b",
                         w, c, {out1, bus1.ready, busy1}, {exp_level(w, odd, c, DIV), 2'b01});
            end
            if (!bus1.ready) low++;
            bus1.data  = 8'($urandom);
            bus1.valid = (c < int'(F) - 2) ? 1'($urandom) : 1'b0;
        end
        @(negedge CLKIN);
        checks++;
        if ({out1, bus1.ready, busy1} !== 3'b110 || low != int'(F)) begin
            failures++;
            $display("FAIL frame_end word=%h out/ready/busy=%b low_cycles=%0d required=110 low=%0d",
                     w, {out1, bus1.ready, busy1}, low, F);
        end
    endtask

    task automatic test_parity();
        test_frame(8'hA5, 1'b0);
        test_frame(8'hA5, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] w1, w2;
        logic       odd;
        w1 = 8'h3C; w2 = 8'hC3; odd = 1'($urandom);
        @(negedge CLKIN);
        bus1.data = w1; bus1.valid = 1'b1; odd1 = odd;
        @(posedge CLKIN);
        for (int c = 0; c < int'(F); c++) begin
            @(negedge CLKIN);
            checks++;
            if ({out1, bus1.ready} !== {exp_level(w1, odd, c, DIV), 1'b0}) begin
                failures++;
                $display("FAIL b2b_first cycle=%0d out/ready=%b required=%b",
                         c, {out1, bus1.ready}, {exp_level(w1, odd, c, DIV), 1'b0});
            end
            if (c == int'(F) / 2) bus1.data = w2;
        end
        @(negedge CLKIN);
        checks++;
        if ({out1, bus1.ready, busy1} !== 3'b110) begin
            failures++;
            $display("FAIL b2b_gap out/ready/busy=%b required=110", {out1, bus1.ready, busy1});
        end
        @(posedge CLKIN);
        #1;
        bus1.valid = 1'b0;
        for (int c = 0; c < int'(F); c++) begin
            @(negedge CLKIN);
            checks++;
            if ({out1, bus1.ready} !== {exp_level(w2, odd, c, DIV), 1'b0}) begin
                failures++;
                $display("FAIL b2b_second cycle=%0d out/ready=%b required=%b",
                         c, {out1, bus1.ready}, {exp_level(w2, odd, c, DIV), 1'b0});
            end
            bus1.data = 8'($urandom);
        end
        @(negedge CLKIN);
        checks++;
        if ({out1, bus1.ready, busy1} !== 3'b110) begin
            failures++;
            $display("FAIL b2b_end out/ready/busy=%b required=110", {out1, bus1.ready, busy1});
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge CLKIN);
        bus1.data = 8'hFF; bus1.valid = 1'b1; odd1 = 1'b0;
        @(posedge CLKIN);
        #1;
        bus1.valid = 1'b0;
        for (int c = 0; c < 13; c++) begin
            @(negedge CLKIN);
            checks++;
            if ({out1, bus1.ready} !== {exp_level(8'hFF, 1'b0, c, DIV), 1'b0}) begin
                failures++;
                $display("FAIL abort_pre cycle=%0d out/ready=%b required=%b",
                         c, {out1, bus1.ready}, {exp_level(8'hFF, 1'b0, c, DIV), 1'b0});
            end
        end
        RESET = 1'b1;
        @(negedge CLKIN);
        RESET = 1'b0;
        checks++;
        if ({out1, bus1.ready, busy1} !== 3'b110) begin
            failures++;
            $display("FAIL abort_reset out/ready/busy=%b required=110", {out1, bus1.ready, busy1});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLKIN);
            checks++;
            if ({out1, bus1.ready, busy1} !== 3'b110) begin
                failures++;
                $display("FAIL abort_idle cycle=%0d out/ready/busy=%b required=110", c, {out1, bus1.ready, busy1});
            end
        end
        test_frame(8'h00, 1'($urandom));
    endtask

    task automatic test_long_stop();
        int low, high;
        low = 0; high = 0;
        @(negedge CLKIN);
        bus2.data = 8'h00; bus2.valid = 1'b1; odd2 = 1'b1;
        @(posedge CLKIN);
        #1;
        bus2.valid = 1'b0;
        for (int c = 0; c < int'(F2); c++) begin
            @(negedge CLKIN);
            checks++;
            if ({out2, bus2.ready} !== {exp_level(8'h00, 1'b1, c, DIV2), 1'b0}) begin
                failures++;
                $display("FAIL long_frame cycle=%0d out/ready=%b required=%b",
                         c, {out2, bus2.ready}, {exp_level(8'h00, 1'b1, c, DIV2), 1'b0});
            end
            if (out2) high++; else low++;
        end
        checks++;
        if (low != int'((1 + NB) * DIV2) || high != int'((PB + 2) * DIV2)) begin
            failures++;
            $display("FAIL long_counts low=%0d high=%0d required low=%0d high=%0d",
                     low, high, (1 + NB) * DIV2, (PB + 2) * DIV2);
        end
        @(negedge CLKIN);
        checks++;
        if ({out2, bus2.ready, busy2} !== 3'b110) begin
            failures++;
            $display("FAIL long_end out/ready/busy=%b required=110", {out2, bus2.ready, busy2});
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, 1'b0);
        test_parity();
        for (int i = 0; i < 6; i++) test_frame(8'($urandom), 1'($urandom));
        test_back_to_back();
        test_reset_mid_frame();
        test_long_stop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
